// File: rtl/svc_stats_avg.sv
// svc_stats_avg: computes avg = sum / count with a radix-2 restoring divider, one quotient bit per cycle.
// Optional macro SVC_STATS_AVG_ROUND_EN adds a one-cycle round-half-up stage after the divide.
module svc_stats_avg #(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [STAT_WIDTH-1:0] sum,
  input  logic [STAT_WIDTH-1:0] count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STAT_WIDTH-1:0] avg,
  output logic                  div_zero
);

  localparam int CW = $clog2(STAT_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(STAT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
`ifdef SVC_STATS_AVG_ROUND_EN
    ROUND = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [STAT_WIDTH-1:0] dvd_q;
  logic [STAT_WIDTH-1:0] divisor_q;
  logic [STAT_WIDTH-1:0] quot_q;
  logic [STAT_WIDTH-1:0] rem_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  div_zero_q;

  logic [STAT_WIDTH:0]   trial;
  logic [STAT_WIDTH:0]   diff;
  logic                  fits;
  logic                  last_div;

  // Partial remainder is one bit wider than the operands so the shift-in never overflows.
  assign trial    = {rem_q, dvd_q[STAT_WIDTH-1]};
  assign diff     = trial - {1'b0, divisor_q};
  assign fits     = ~diff[STAT_WIDTH];
  assign last_div = (bit_cnt_q == LAST_BIT);

`ifdef SVC_STATS_AVG_ROUND_EN
  logic [STAT_WIDTH:0] rem_x2;
  logic                round_up;

  assign rem_x2   = {rem_q, 1'b0};
  assign round_up = (rem_x2 >= {1'b0, divisor_q});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (count == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        if (last_div) begin
`ifdef SVC_STATS_AVG_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SVC_STATS_AVG_ROUND_EN
      ROUND: begin
        state_d = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Quotient bits shift in LSB-first position while dividend bits shift out MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q      <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      bit_cnt_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q      <= sum;
            divisor_q  <= count;
            quot_q     <= '0;
            rem_q      <= '0;
            bit_cnt_q  <= '0;
            div_zero_q <= (count == '0);
          end
        end
        DIV: begin
          dvd_q     <= dvd_q << 1;
          quot_q    <= {quot_q[STAT_WIDTH-2:0], fits};
          rem_q     <= fits ? diff[STAT_WIDTH-1:0] : trial[STAT_WIDTH-1:0];
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
`ifdef SVC_STATS_AVG_ROUND_EN
        ROUND: begin
          if (round_up) begin
            quot_q <= quot_q + STAT_WIDTH'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign avg      = quot_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_svc_stats_avg.sv
// tb_svc_stats_avg: scoreboard bench for svc_stats_avg at STAT_WIDTH = 8, directed cases plus random traffic.
// Honours SVC_STATS_AVG_ROUND_EN so the reference model rounds when the design does.
module tb_svc_stats_avg;

  localparam int W = 8;
`ifdef SVC_STATS_AVG_ROUND_EN
  localparam int DIV_LAT = W + 2;
`else
  localparam int DIV_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic [W-1:0] count;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] avg;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;
  bit first_seen = 1'b0;

  typedef struct {
    logic [W-1:0] avg;
    logic         dz;
    int           due;
  } exp_t;

  exp_t exp_q[$];

  svc_stats_avg #(.STAT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .avg       (avg),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference: integer division, optional round-half-up, and the cycle the result should first appear.
  function automatic exp_t model(input int s, input int c, input int now);
    exp_t e;
    int   q;
    if (c == 0) begin
      e.avg = '0;
      e.dz  = 1'b1;
      e.due = now + 1;
    end else begin
      q = s / c;
`ifdef SVC_STATS_AVG_ROUND_EN
      if (2 * (s % c) >= c) q = q + 1;
`endif
      e.avg = W'(q);
      e.dz  = 1'b0;
      e.due = now + DIV_LAT;
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: records transfers into the scoreboard and checks every cycle a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      first_seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(sum), int'(count), cyc));
      end
      if (out_valid) begin
        check_output("in_ready_in_done", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          if (!first_seen) begin
            check_output("latency", 32'(cyc), 32'(exp_q[0].due));
            first_seen = 1'b1;
          end
          check_output("avg", 32'(avg), 32'(exp_q[0].avg));
          check_output("div_zero", 32'(div_zero), 32'(exp_q[0].dz));
          if (out_ready) begin
            void'(exp_q.pop_front());
            first_seen = 1'b0;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        fail_now("result_late");
        void'(exp_q.pop_front());
        first_seen = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] s, input logic [W-1:0] c);
    int n = 0;
    in_valid = 1'b1;
    sum      = s;
    count    = c;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum      = W'($urandom);
    count    = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail_now("valid_timeout");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum       = '0;
    count     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_avg", 32'(avg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_in_ready", 32'(in_ready), 32'd1);
    check_output("post_reset_out_valid", 32'(out_valid), 32'd0);
    check_output("post_reset_avg", 32'(avg), 32'd0);
    check_output("post_reset_div_zero", 32'(div_zero), 32'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    apply_stimulus(8'd100, 8'd7);
    wait_idle();
    apply_stimulus(8'd100, 8'd8);
    wait_idle();
    apply_stimulus(8'd55, 8'd0);
    wait_idle();

    // Held result under backpressure while unrelated operands are offered.
    out_ready = 1'b0;
    apply_stimulus(8'd255, 8'd1);
    wait_valid();
    repeat (5) begin
      in_valid = 1'b1;
      sum      = W'($urandom);
      count    = W'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_output("held_avg", 32'(avg), 32'd255);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("in_ready_after_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the fourth divide cycle abandons the operation.
    apply_stimulus(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_out_valid", 32'(out_valid), 32'd0);
    check_output("midreset_avg", 32'(avg), 32'd0);
    check_output("midreset_div_zero", 32'(div_zero), 32'd0);
    check_output("midreset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_output("post_midreset_out_valid", 32'(out_valid), 32'd0);
    apply_stimulus(8'd200, 8'd3);
    wait_idle();

    apply_stimulus(8'd10, 8'd3);
    apply_stimulus(8'd9, 8'd3);
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int c;
      case ($urandom_range(0, 5))
        0:       c = 0;
        1:       c = 1;
        default: c = int'($urandom_range(1, 255));
      endcase
      apply_stimulus(W'($urandom), W'(c));
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
